// File: rtl/sha_nonce_scheduler.sv
// sha_nonce_scheduler: sweeps a nonce range through a SHA core and stops on the first digest below target.
//   clk, rst (async, active high)
//   start/abort                   sweep control (abort wins over everything)
//   msg_prefix, nonce_start,
//   nonce_end, target             sweep setup, sampled on an accepted start
//   sha_msg/sha_begin/sha_enable  drive the core; sha_complete/sha_digest come back from it
//   busy                          high outside IDLE
//   found/exhausted/timeout       sticky sweep outcome
//   found_nonce/found_digest      winning nonce and its digest
//   hash_count                    digests checked in the current or last sweep (saturating)
module sha_nonce_scheduler #(
   parameter int TIMEOUT_CYCLES = 128,
   parameter int CNT_W          = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [479:0]     msg_prefix,
   input  logic [31:0]      nonce_start,
   input  logic [31:0]      nonce_end,
   input  logic [255:0]     target,
   output logic [511:0]     sha_msg,
   output logic             sha_begin,
   output logic             sha_enable,
   input  logic             sha_complete,
   input  logic [255:0]     sha_digest,
   output logic             busy,
   output logic             found,
   output logic             exhausted,
   output logic             timeout,
   output logic [31:0]      found_nonce,
   output logic [255:0]     found_digest,
   output logic [CNT_W-1:0] hash_count
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CHECK} state_t;
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   state_t state, next;
   logic [479:0] prefix_q;
   logic [31:0] nonce_q, nonce_end_q;
   logic [255:0] target_q, digest_q;
   logic [WD_W-1:0] wd;
   logic accept, empty, got, expired, hit, last;
   assign sha_msg = {prefix_q, nonce_q};
   always_comb begin
      accept     = state == IDLE && start && !abort;
      empty      = nonce_start > nonce_end;
      // wd==0 marks the first WAIT cycle, where the core still shows the previous complete
      got        = state == WAIT && wd != '0 && sha_complete;
      expired    = state == WAIT && !got && wd == WD_W'(TIMEOUT_CYCLES - 1);
      hit        = digest_q < target_q;
      last       = nonce_q == nonce_end_q;
      sha_begin  = state == ISSUE && !abort;
      sha_enable = (state == ISSUE || state == WAIT) && !abort;
      busy       = state != IDLE;
      next       = state;
      case (state)
         IDLE:    next = (accept && !empty) ? ISSUE : IDLE;
         ISSUE:   next = WAIT;
         WAIT:    next = got ? CHECK : expired ? IDLE : WAIT;
         CHECK:   next = (hit || last) ? IDLE : ISSUE;
         default: next = IDLE;
      endcase
      if (abort) next = IDLE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prefix_q     <= '0;
         nonce_q      <= '0;
         nonce_end_q  <= '0;
         target_q     <= '0;
         digest_q     <= '0;
         wd           <= '0;
         found        <= 1'b0;
         exhausted    <= 1'b0;
         timeout      <= 1'b0;
         found_nonce  <= '0;
         found_digest <= '0;
         hash_count   <= '0;
      end else begin
         if (accept) begin
            prefix_q    <= msg_prefix;
            target_q    <= target;
            nonce_end_q <= nonce_end;
            nonce_q     <= nonce_start;
            found       <= 1'b0;
            exhausted   <= empty;
            timeout     <= 1'b0;
            hash_count  <= '0;
         end
         if (state == ISSUE) wd <= '0;
         if (state == WAIT && !abort) begin
            wd <= wd + 1'b1;
            if (got) digest_q <= sha_digest;
            if (expired) timeout <= 1'b1;
         end
         // end-of-range is tested before the increment so nonce_end=FFFFFFFF never wraps
         if (state == CHECK && !abort) begin
            hash_count <= hash_count + {{(CNT_W-1){1'b0}}, ~&hash_count};
            if (hit) begin
               found        <= 1'b1;
               found_nonce  <= nonce_q;
               found_digest <= digest_q;
            end else if (last) exhausted <= 1'b1;
            else nonce_q <= nonce_q + 32'd1;
         end
      end
   end
endmodule

// File: tb/tb_sha_nonce_scheduler.sv
// tb_sha_nonce_scheduler: stub SHA core plus scenario tasks checked against a loop-based sweep model.
module tb_sha_nonce_scheduler;
   logic clk = 0, rst = 1, start = 0, abort = 0;
   logic [479:0] msg_prefix = '0;
   logic [31:0] nonce_start = '0, nonce_end = '0;
   logic [255:0] target = '0;
   logic [511:0] sha_msg;
   logic sha_begin, sha_enable, busy, found, exhausted, timeout;
   logic sha_complete = 0;
   logic [255:0] sha_digest = '0;
   logic [31:0] found_nonce;
   logic [255:0] found_digest;
   logic [31:0] hash_count;
   int checks = 0, passed = 0;
   int lat = 70, cnt = 0, begins = 0, wide = 0, prefix_bad = 0;
   bit hang = 0, mode = 0, run = 0, prev_b = 0;
   logic [31:0] key = '0;
   logic [479:0] exp_prefix = '0;

   sha_nonce_scheduler #(.TIMEOUT_CYCLES(128), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .msg_prefix(msg_prefix),
      .nonce_start(nonce_start), .nonce_end(nonce_end), .target(target), .sha_msg(sha_msg),
      .sha_begin(sha_begin), .sha_enable(sha_enable), .sha_complete(sha_complete),
      .sha_digest(sha_digest), .busy(busy), .found(found), .exhausted(exhausted),
      .timeout(timeout), .found_nonce(found_nonce), .found_digest(found_digest),
      .hash_count(hash_count));

   always #5 clk = ~clk;

   function automatic logic [255:0] dfun(input logic [511:0] m, input bit md, input logic [31:0] k);
      return md ? {(m[31:0] * 32'h9E3779B1) ^ k, m[255:32]} : {32'hFFFFFFFF - m[31:0], 224'h0};
   endfunction

   // Stub core: complete stays at its old value during the cycle after begin, then drops until latency expires.
   always @(posedge clk) begin
      prev_b <= sha_begin;
      if (sha_begin) begins <= begins + 1;
      if (sha_begin && prev_b) wide <= wide + 1;
      if (sha_begin) begin
         run <= 1;
         cnt <= 0;
         sha_digest <= dfun(sha_msg, mode, key);
         if (sha_msg[511:32] !== exp_prefix) prefix_bad <= prefix_bad + 1;
      end else if (run) begin
         cnt <= cnt + 1;
         if (!hang && cnt + 1 >= lat) begin
            sha_complete <= 1;
            run <= 0;
         end else sha_complete <= 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [31:0] s, input logic [31:0] e, input logic [255:0] t, input logic [479:0] p);
      msg_prefix = p; nonce_start = s; nonce_end = e; target = t; exp_prefix = p; start = 1;
      step(1);
      start = 0;
      msg_prefix = {15{$urandom()}}; nonce_start = $urandom; nonce_end = $urandom; target = {8{$urandom()}};
   endtask

   task automatic wait_idle(input int budget, input string name);
      for (int i = 0; i < budget && busy; i++) step(1);
      checks++; if (busy !== 1'b0) $display("FAIL %s idle_wait busy=%0b want 0", name, busy); else passed++;
   endtask

   task automatic test_reset;
      step(2);
      checks++; if ({sha_msg, sha_begin, sha_enable, found, exhausted, timeout, found_nonce, found_digest, hash_count} !== '0)
         $display("FAIL reset_outputs got nonzero want all 0"); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else passed++;
      rst = 0;
      step(1);
   endtask

   task automatic test_found;
      mode = 0; lat = 70;
      do_start(10, 20, {32'hFFFFFFF0, 224'h0}, {15{32'hA5A5_0001}});
      wait_idle(3000, "t1");
      checks++; if (found !== 1'b1) $display("FAIL t1_found got %0b want 1", found); else passed++;
      checks++; if (found_nonce !== 32'd16) $display("FAIL t1_nonce got %0d want 16", found_nonce); else passed++;
      checks++; if (hash_count !== 32'd7) $display("FAIL t1_count got %0d want 7", hash_count); else passed++;
      checks++; if (found_digest !== {32'hFFFFFFEF, 224'h0}) $display("FAIL t1_digest got %h want %h", found_digest, {32'hFFFFFFEF, 224'h0}); else passed++;
      checks++; if (exhausted !== 1'b0) $display("FAIL t1_exh got %0b want 0", exhausted); else passed++;
   endtask

   task automatic test_exhaust;
      int b0 = begins, w0 = wide;
      do_start(0, 3, '0, {15{32'h1234_5678}});
      wait_idle(2000, "t2");
      checks++; if ({exhausted, found} !== 2'b10) $display("FAIL t2_flags got exh=%0b found=%0b want 1 0", exhausted, found); else passed++;
      checks++; if (hash_count !== 32'd4) $display("FAIL t2_count got %0d want 4", hash_count); else passed++;
      checks++; if (begins - b0 !== 4) $display("FAIL t2_begins got %0d want 4", begins - b0); else passed++;
      checks++; if (wide !== w0) $display("FAIL t2_begin_width got %0d wide pulses want 0", wide - w0); else passed++;
   endtask

   task automatic test_no_wrap;
      int b0 = begins;
      do_start(32'hFFFFFFFE, 32'hFFFFFFFF, '0, {15{32'h0F0F_F0F0}});
      wait_idle(1000, "t3");
      step(200);
      checks++; if (hash_count !== 32'd2) $display("FAIL t3_count got %0d want 2", hash_count); else passed++;
      checks++; if (exhausted !== 1'b1) $display("FAIL t3_exh got %0b want 1", exhausted); else passed++;
      checks++; if (sha_msg[31:0] !== 32'hFFFFFFFF) $display("FAIL t3_msg got %h want ffffffff", sha_msg[31:0]); else passed++;
      checks++; if (begins - b0 !== 2 || busy !== 1'b0) $display("FAIL t3_nowrap got %0d begins busy=%0b want 2 0", begins - b0, busy); else passed++;
   endtask

   task automatic test_timeout;
      hang = 1;
      do_start(1, 5, '1, {15{32'hCAFE_0000}});
      for (int i = 0; i < 10 && !sha_begin; i++) step(1);
      step(1);
      step(127);
      checks++; if ({timeout, busy} !== 2'b01) $display("FAIL t4_early got to=%0b busy=%0b want 0 1", timeout, busy); else passed++;
      step(1);
      checks++; if (timeout !== 1'b1) $display("FAIL t4_timeout got %0b want 1", timeout); else passed++;
      checks++; if ({sha_enable, busy, found, hash_count} !== '0) $display("FAIL t4_after got en=%0b busy=%0b found=%0b cnt=%0d want 0", sha_enable, busy, found, hash_count); else passed++;
      hang = 0;
   endtask

   task automatic test_abort;
      int b0 = begins;
      lat = 70;
      do_start(1, 9, '0, {15{32'h5555_AAAA}});
      for (int i = 0; i < 400 && begins != b0 + 2; i++) step(1);
      step(4);
      start = 1; nonce_start = 99;
      step(1);
      start = 0;
      checks++; if (sha_msg[31:0] !== 32'd2) $display("FAIL t5_busy_start got nonce %0d want 2", sha_msg[31:0]); else passed++;
      step(4);
      abort = 1;
      #1;
      checks++; if ({sha_enable, sha_begin} !== 2'b00) $display("FAIL t5_comb got en=%0b beg=%0b want 0 0", sha_enable, sha_begin); else passed++;
      step(1);
      abort = 0;
      checks++; if ({busy, sha_enable, found, exhausted, timeout} !== '0) $display("FAIL t5_idle got %b want 00000", {busy, sha_enable, found, exhausted, timeout}); else passed++;
      checks++; if (hash_count !== 32'd1) $display("FAIL t5_count got %0d want 1", hash_count); else passed++;
      start = 1; abort = 1;
      step(1);
      start = 0; abort = 0;
      checks++; if (busy !== 1'b0) $display("FAIL t5_start_abort got busy=%0b want 0", busy); else passed++;
      do_start(0, 0, '1, {15{32'h0000_0007}});
      checks++; if ({busy, hash_count} !== {1'b1, 32'd0}) $display("FAIL t5_restart got busy=%0b cnt=%0d want 1 0", busy, hash_count); else passed++;
      wait_idle(500, "t5");
      checks++; if ({found, found_nonce} !== {1'b1, 32'd0}) $display("FAIL t5_found got %0b/%0d want 1/0", found, found_nonce); else passed++;
   endtask

   task automatic test_random;
      mode = 1;
      for (int it = 0; it < 8; it++) begin
         logic [479:0] p;
         logic [31:0] s, e;
         logic [255:0] t, d, dig_e;
         logic f_e = 0, x_e = 0;
         logic [31:0] n_e = 0;
         int c_e = 0;
         key = $urandom; lat = $urandom_range(2, 30);
         for (int k = 0; k < 15; k++) p = {p[447:0], $urandom()};
         for (int k = 0; k < 8; k++) t = {t[223:0], $urandom()};
         s = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - $urandom_range(0, 6) : $urandom;
         e = (s > 32'hFFFFFFF8) ? 32'hFFFFFFFF : s + $urandom_range(0, 7);
         if (it == 7) e = s - 1;
         dig_e = '0;
         if (s > e) x_e = 1;
         else for (longint n = s; n <= e && !f_e; n++) begin
            d = dfun({p, n[31:0]}, 1'b1, key);
            c_e++;
            if (d < t) begin f_e = 1; n_e = n[31:0]; dig_e = d; end
            else if (n == e) x_e = 1;
         end
         do_start(s, e, t, p);
         wait_idle(2000, "rand");
         checks++; if ({found, exhausted} !== {f_e, x_e}) $display("FAIL rand%0d_flags got %b want %b", it, {found, exhausted}, {f_e, x_e}); else passed++;
         checks++; if (hash_count !== 32'(c_e)) $display("FAIL rand%0d_count got %0d want %0d", it, hash_count, c_e); else passed++;
         if (f_e) begin
            checks++; if ({found_nonce, found_digest} !== {n_e, dig_e}) $display("FAIL rand%0d_hit got %h want %h", it, found_nonce, n_e); else passed++;
         end
      end
      checks++; if (prefix_bad !== 0) $display("FAIL prefix_latch got %0d bad msgs want 0", prefix_bad); else passed++;
      mode = 0;
   endtask

   task automatic test_empty_and_reset;
      int b0 = begins;
      do_start(5, 3, '1, {15{32'h3333_4444}});
      checks++; if ({exhausted, busy} !== 2'b10) $display("FAIL t6_empty got exh=%0b busy=%0b want 1 0", exhausted, busy); else passed++;
      step(5);
      checks++; if (begins !== b0) $display("FAIL t6_nobegin got %0d begins want 0", begins - b0); else passed++;
      lat = 20;
      do_start(100, 110, '0, {15{32'h7777_8888}});
      for (int i = 0; i < 200 && begins != b0 + 2; i++) step(1);
      step(3);
      rst = 1;
      #1;
      checks++; if ({busy, sha_msg, sha_begin, sha_enable, found, exhausted, timeout, found_nonce, found_digest, hash_count} !== '0)
         $display("FAIL t6_async_reset got busy=%0b cnt=%0d msg_lo=%h want all 0", busy, hash_count, sha_msg[31:0]); else passed++;
      step(1);
      rst = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout got hang want finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_found;
      test_exhaust;
      test_no_wrap;
      test_timeout;
      test_abort;
      test_random;
      test_empty_and_reset;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule

// File: doc/sha_nonce_scheduler.md
Name: sha_nonce_scheduler

Overview:
Sequences the SHA computational block across a range of nonces for the miner datapath. For each nonce it builds the 512-bit message from a 480-bit prefix and the 32-bit nonce, then pulses begin and waits for complete. It compares each digest against a 256-bit target and stops on the first hit or when the range is exhausted. A cycle watchdog detects a hung core, and a hash counter reports throughput.

Parameters:
TIMEOUT_CYCLES, 128, max cycles in WAIT per hash before timeout is flagged (must be > core latency)
CNT_W, 32, width of hash_count

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous active-high reset
start  in  1  one-cycle request to begin a sweep; honoured only in IDLE
abort  in  1  stop sweep; priority over every other event
msg_prefix  in  480  upper message bits, sampled on accepted start
nonce_start  in  32  first nonce, sampled on accepted start
nonce_end  in  32  last nonce (inclusive), sampled on accepted start
target  in  256  hit threshold, sampled on accepted start
sha_msg  out  512  {prefix_q, nonce_q} to core inputSHAMsg
sha_begin  out  1  to core beginComputation
sha_enable  out  1  to core enableComputation
sha_complete  in  1  from core computationComplete (level)
sha_digest  in  256  from core shaOutput
busy  out  1  high in any state other than IDLE
found  out  1  sticky: hit found
exhausted  out  1  sticky: range finished with no hit
timeout  out  1  sticky: watchdog expired
found_nonce  out  32  nonce that produced the hit
found_digest  out  256  digest of the hit
hash_count  out  CNT_W  digests checked in current or last sweep

Behaviour:
- Reset (async, rst=1): state IDLE; every output 0, including sha_msg, found_nonce, found_digest and hash_count.
- States: IDLE, ISSUE, WAIT, CHECK.
- IDLE, start=1, abort=0:
  - Latch prefix, target, nonce_end; nonce_q<=nonce_start.
  - Clear found, exhausted, timeout and hash_count.
  - If nonce_start>nonce_end (unsigned): set exhausted, stay IDLE, no hash issued.
  - Otherwise go to ISSUE.
- ISSUE (exactly 1 cycle): sha_begin=1, sha_enable=1; watchdog cleared; go to WAIT.
- WAIT:
  - sha_enable=1, sha_begin=0.
  - sha_complete is ignored on the first WAIT cycle (the core still shows the stale complete).
  - From the 2nd cycle on, sha_complete=1 registers sha_digest into digest_q and goes to CHECK.
  - Watchdog increments each WAIT cycle. When it reaches TIMEOUT_CYCLES with no complete: timeout<=1, go to IDLE.
- CHECK (1 cycle):
  - sha_enable=0; hash_count++ (saturates at all-ones).
  - Hit if digest_q < target_q (unsigned 256-bit, strict).
  - Hit: found<=1, found_nonce<=nonce_q, found_digest<=digest_q, go to IDLE.
  - Else if nonce_q==nonce_end_q: exhausted<=1, go to IDLE.
  - Else nonce_q++, go to ISSUE.
  - The end compare happens before the increment, so nonce_end=FFFFFFFF never wraps.
- sha_msg is combinational from the registers, {prefix_q, nonce_q}, and is stable from ISSUE through CHECK.
- Per-hash overhead: 3 cycles (ISSUE, first WAIT guard, CHECK) plus core latency.
- abort=1 in any state: next state IDLE; sha_begin and sha_enable go 0 combinationally.
  - No status flag is set; hash_count is kept.
  - abort in CHECK beats a simultaneous hit.
  - start together with abort in IDLE is ignored.
- start outside IDLE is ignored. Inputs may change freely after an accepted start.

Test Plan:
1. Stub core completes 70 cycles after begin with digest={32'hFFFFFFFF-nonce, 224'h0}. Target={32'hFFFFFFF0, 224'h0}, sweep 10..20. Required: found=1, found_nonce=16, hash_count=7, found_digest={32'hFFFFFFEF, 224'h0}, busy low afterwards.
2. Same stub, sweep 0..3 with target 256'h0. Required: exhausted=1, found=0, hash_count=4, and exactly 4 sha_begin pulses, each 1 cycle wide.
3. Sweep FFFFFFFE..FFFFFFFF with no hit. Required: hash_count=2, exhausted=1, last sha_msg[31:0]=FFFFFFFF, no third begin (no wrap).
4. Stub never asserts complete, TIMEOUT_CYCLES=128. Required: timeout=1 exactly 128 cycles after entering WAIT, sha_enable=0, busy=0.
5. Assert abort in the 10th WAIT cycle of hash 2. Required: next cycle IDLE, sha_enable=0, found/exhausted/timeout=0, hash_count=1. A new start is then accepted and clears hash_count.
6. Sweep 5..3. Required: exhausted=1 the cycle after start, no sha_begin. Also assert rst mid-WAIT: all outputs 0 asynchronously.
